// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares the single cache_controller port among three requesters,
// one outstanding transaction at a time, with a watchdog that aborts stalled transactions.
module mem_req_arbiter #(
    parameter int unsigned ADDR_LEN = 27,
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned NREQ     = 3,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_LEN-1:0] req_addr,
    input  logic [NREQ*DATA_LEN-1:0] req_wdata,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic [DATA_LEN-1:0]      rsp_rdata,
    output logic                     c_req,
    output logic                     c_read,
    output logic [ADDR_LEN-1:0]      c_addr,
    output logic [DATA_LEN-1:0]      c_wdata,
    input  logic [DATA_LEN-1:0]      c_rdata,
    input  logic                     c_done,
    output logic                     busy,
    output logic [1:0]               grant_id
);

    localparam int unsigned GW = 2;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [NREQ-1:0]      req_done_nxt, req_err_nxt;
    logic [DATA_LEN-1:0]  rsp_rdata_nxt;
    logic                 c_req_nxt, c_read_nxt, busy_nxt;
    logic [ADDR_LEN-1:0]  c_addr_nxt;
    logic [DATA_LEN-1:0]  c_wdata_nxt;
    logic [GW-1:0]        grant_id_nxt;

    logic                 any_req;
    logic [GW-1:0]        pick;
    logic                 timeout_hit;
    logic [ADDR_LEN-1:0]  addr_arr  [NREQ];
    logic [DATA_LEN-1:0]  wdata_arr [NREQ];

    // Unpack the flat per-port buses so the granted port can be selected by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_LEN +: ADDR_LEN];
        assign wdata_arr[gi] = req_wdata[gi*DATA_LEN +: DATA_LEN];
    end

    // First requesting port scanning cyclically from the port after the last grant.
    always_comb begin
        logic [GW-1:0] idx;
        any_req = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = GW'((32'(rr_ptr) + i) % NREQ);
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_LAST);

    // State and all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_ptr    <= GW'(NREQ - 1);
            timer     <= '0;
            req_done  <= '0;
            req_err   <= '0;
            rsp_rdata <= '0;
            c_req     <= 1'b0;
            c_read    <= 1'b0;
            c_addr    <= '0;
            c_wdata   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            timer     <= timer_nxt;
            req_done  <= req_done_nxt;
            req_err   <= req_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            c_req     <= c_req_nxt;
            c_read    <= c_read_nxt;
            c_addr    <= c_addr_nxt;
            c_wdata   <= c_wdata_nxt;
            busy      <= busy_nxt;
            grant_id  <= grant_id_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_BUSY;
            S_BUSY:  if (c_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the cache-side copies only change on a grant.
    always_comb begin
        rr_ptr_nxt    = rr_ptr;
        timer_nxt     = timer;
        req_done_nxt  = '0;
        req_err_nxt   = '0;
        rsp_rdata_nxt = rsp_rdata;
        c_req_nxt     = c_req;
        c_read_nxt    = c_read;
        c_addr_nxt    = c_addr;
        c_wdata_nxt   = c_wdata;
        grant_id_nxt  = grant_id;
        busy_nxt      = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                c_req_nxt = 1'b0;
                if (any_req) begin
                    c_req_nxt    = 1'b1;
                    c_read_nxt   = ~req_we[pick];
                    c_addr_nxt   = addr_arr[pick];
                    c_wdata_nxt  = wdata_arr[pick];
                    grant_id_nxt = pick;
                    rr_ptr_nxt   = pick;
                    timer_nxt    = '0;
                end
            end
            S_BUSY: begin
                if (c_done) begin
                    c_req_nxt              = 1'b0;
                    rsp_rdata_nxt          = c_rdata;
                    req_done_nxt[grant_id] = 1'b1;
                end else if (timeout_hit) begin
                    c_req_nxt              = 1'b0;
                    rsp_rdata_nxt          = '0;
                    req_done_nxt[grant_id] = 1'b1;
                    req_err_nxt[grant_id]  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_RESP: begin
                c_req_nxt = 1'b0;
            end
            default: begin
                c_req_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_mem_req_arbiter;

    localparam int unsigned AL = 27;
    localparam int unsigned DL = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned TO = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req_valid, req_we, req_done, req_err;
    logic [NR*AL-1:0] req_addr;
    logic [NR*DL-1:0] req_wdata;
    logic [DL-1:0]    rsp_rdata, c_wdata, c_rdata;
    logic             c_req, c_read, c_done, busy;
    logic [AL-1:0]    c_addr;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;
    int exp_last = 2;

    mem_req_arbiter #(.ADDR_LEN(AL), .DATA_LEN(DL), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done), .req_err(req_err),
        .rsp_rdata(rsp_rdata), .c_req(c_req), .c_read(c_read), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_done(c_done), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic v, input logic we,
                              input logic [AL-1:0] a, input logic [DL-1:0] d);
        req_valid[p]         = v;
        req_we[p]            = we;
        req_addr[p*AL +: AL] = a;
        req_wdata[p*DL +: DL] = d;
    endtask

    // Reference arbitration rule: first requester after the last grant, cyclic order 0,1,2.
    function automatic int next_grant(input int last, input logic [2:0] v);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (last + k) % 3;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rstn = 1'b0; req_valid = '1; req_we = '0; req_addr = '1; req_wdata = '1;
        c_rdata = '1; c_done = 1'b1;
        tick; tick;
        checks++; if ({c_req, busy, c_read, grant_id, req_done, req_err} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 0", {c_req, busy, c_read, grant_id, req_done, req_err}); end
        checks++; if ({c_addr, c_wdata, rsp_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: got %h exp 0", {c_addr, c_wdata, rsp_rdata}); end
        req_valid = '0; c_done = 1'b0; c_rdata = '0;
        rstn = 1'b1;
        tick;
        checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL reset_idle: c_req got %b exp 0", c_req); end
        exp_last = 2;
    endtask

    task automatic test_single_read;
        drive_port(1, 1'b1, 1'b0, 27'h0000100, 32'h0);
        tick;
        checks++; if ({c_req, c_read, busy, grant_id} !== 5'b111_01) begin
            errors++; $display("FAIL rd_grant: got %b exp 11101", {c_req, c_read, busy, grant_id}); end
        checks++; if (c_addr !== 27'h0000100) begin errors++; $display("FAIL rd_addr: got %h exp 0000100", c_addr); end
        repeat (4) tick;
        checks++; if ({c_req, req_done} !== 4'b1_000) begin
            errors++; $display("FAIL rd_wait: got %b exp 1000", {c_req, req_done}); end
        c_done = 1'b1; c_rdata = 32'hDEADBEEF;
        tick;
        checks++; if ({c_req, req_done, req_err} !== 7'b0_010_000) begin
            errors++; $display("FAIL rd_done: got %b exp 0010000", {c_req, req_done, req_err}); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h exp deadbeef", rsp_rdata); end
        c_done = 1'b0; req_valid = '0;
        tick;
        checks++; if ({c_req, busy, req_done} !== 5'b0) begin
            errors++; $display("FAIL rd_after1: got %b exp 00000", {c_req, busy, req_done}); end
        tick;
        checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL rd_after2: c_req got %b exp 0", c_req); end
        exp_last = 1;
    endtask

    task automatic test_single_write;
        int bad;
        bad = 0;
        drive_port(2, 1'b1, 1'b1, 27'h7FFFFFC, 32'h12345678);
        tick;
        checks++; if ({c_req, c_read, grant_id} !== 4'b10_10) begin
            errors++; $display("FAIL wr_grant: got %b exp 1010", {c_req, c_read, grant_id}); end
        checks++; if ({c_addr, c_wdata} !== {27'h7FFFFFC, 32'h12345678}) begin
            errors++; $display("FAIL wr_bus: got %h/%h exp 7fffffc/12345678", c_addr, c_wdata); end
        for (int i = 0; i < 3; i++) begin
            drive_port(2, (i != 1), 1'b0, AL'($urandom), $urandom);
            tick;
            if ({c_req, c_read, c_addr, c_wdata} !== {2'b10, 27'h7FFFFFC, 32'h12345678}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wr_stable: got %0d unstable cycles exp 0", bad); end
        c_done = 1'b1;
        tick;
        checks++; if ({req_done, req_err} !== 6'b100_000) begin
            errors++; $display("FAIL wr_done: got %b exp 100000", {req_done, req_err}); end
        c_done = 1'b0; req_valid = '0;
        tick;
        exp_last = 2;
    endtask

    task automatic test_round_robin;
        int cnt [3];
        int n, g;
        cnt = '{0, 0, 0};
        for (int p = 0; p < 3; p++) drive_port(p, 1'b1, 1'b0, AL'(32'h1000 + p), 32'(p));
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (c_req !== 1'b1 && n < 10) begin tick; n++; end
            checks++; if (n !== 1) begin errors++; $display("FAIL rr_gap: t=%0d cycles to c_req got %0d exp 1", t, n); end
            g = next_grant(exp_last, 3'b111);
            checks++; if ({30'b0, grant_id} !== g) begin
                errors++; $display("FAIL rr_grant: t=%0d got %0d exp %0d", t, grant_id, g); end
            c_done = 1'b1;
            tick;
            checks++; if (req_done !== 3'(1 << g)) begin
                errors++; $display("FAIL rr_done: t=%0d got %b exp %b", t, req_done, 3'(1 << g)); end
            for (int p = 0; p < 3; p++) if (req_done[p]) cnt[p]++;
            c_done = 1'b0;
            exp_last = g;
            tick;
            checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL rr_idle: t=%0d c_req got %b exp 0", t, c_req); end
        end
        req_valid = '0;
        tick;
        checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2) begin
            errors++; $display("FAIL rr_count: got %0d/%0d/%0d exp 2/2/2", cnt[0], cnt[1], cnt[2]); end
    endtask

    task automatic test_timeout;
        int n, bad;
        n = 0; bad = 0;
        c_rdata = 32'hA5A5A5A5;
        drive_port(0, 1'b1, 1'b0, 27'h55, 32'h0);
        tick;
        while (c_req === 1'b1 && n < 40) begin
            n++;
            if (req_done !== 3'b000) bad++;
            tick;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL to_len: c_req high got %0d exp 16", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early: got %0d early done exp 0", bad); end
        checks++; if ({req_done, req_err} !== 6'b001_001) begin
            errors++; $display("FAIL to_pulse: got %b exp 001001", {req_done, req_err}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_data: got %h exp 0", rsp_rdata); end
        req_valid = '0;
        tick;
        checks++; if ({req_done, req_err} !== 6'b0) begin
            errors++; $display("FAIL to_clear: got %b exp 000000", {req_done, req_err}); end
        exp_last = 0;
        drive_port(1, 1'b1, 1'b0, 27'h200, 32'h0);
        tick;
        checks++; if ({c_req, grant_id} !== 3'b1_01) begin
            errors++; $display("FAIL to_next_grant: got %b exp 101", {c_req, grant_id}); end
        tick;
        c_done = 1'b1; c_rdata = 32'hCAFEF00D;
        tick;
        checks++; if ({req_done, req_err, rsp_rdata} !== {6'b010_000, 32'hCAFEF00D}) begin
            errors++; $display("FAIL to_next_done: got %b/%h exp 010000/cafef00d", {req_done, req_err}, rsp_rdata); end
        c_done = 1'b0; req_valid = '0;
        tick;
        exp_last = 1;
    endtask

    task automatic test_collision;
        c_rdata = 32'h0BADCAFE;
        drive_port(2, 1'b1, 1'b0, 27'h300, 32'h0);
        tick;
        repeat (15) tick;
        checks++; if ({c_req, req_done, grant_id} !== 6'b1_000_10) begin
            errors++; $display("FAIL col_busy16: got %b exp 100010", {c_req, req_done, grant_id}); end
        c_done = 1'b1;
        tick;
        checks++; if ({req_done, req_err} !== 6'b100_000) begin
            errors++; $display("FAIL col_pulse: got %b exp 100000", {req_done, req_err}); end
        checks++; if (rsp_rdata !== 32'h0BADCAFE) begin errors++; $display("FAIL col_data: got %h exp 0badcafe", rsp_rdata); end
        c_done = 1'b0; req_valid = '0;
        tick;
        exp_last = 2;
    endtask

    task automatic test_reset_mid;
        drive_port(1, 1'b1, 1'b1, 27'h400, 32'h1);
        tick; tick; tick;
        rstn = 1'b0;
        tick;
        checks++; if ({c_req, busy, req_done, grant_id} !== 7'b0) begin
            errors++; $display("FAIL rst_mid: got %b exp 0000000", {c_req, busy, req_done, grant_id}); end
        drive_port(0, 1'b1, 1'b0, 27'h500, 32'h0);
        req_valid = 3'b111;
        tick;
        checks++; if ({c_req, req_done} !== 4'b0) begin
            errors++; $display("FAIL rst_hold: got %b exp 0000", {c_req, req_done}); end
        rstn = 1'b1;
        tick;
        checks++; if ({c_req, grant_id, c_addr} !== {3'b1_00, 27'h500}) begin
            errors++; $display("FAIL rst_regrant: got %b/%h exp 100/0000500", {c_req, grant_id}, c_addr); end
        req_valid = 3'b001;
        c_done = 1'b1;
        tick;
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL rst_done: got %b exp 001", req_done); end
        c_done = 1'b0; req_valid = '0;
        tick;
        exp_last = 0;
    endtask

    task automatic test_random;
        logic [AL-1:0] a [3];
        logic [DL-1:0] d [3];
        logic [2:0]    w, mask;
        logic [DL-1:0] rd;
        int g, lat, bad;
        for (int it = 0; it < 60; it++) begin
            mask = 3'($urandom_range(1, 7));
            w    = 3'($urandom);
            for (int p = 0; p < 3; p++) begin
                a[p] = AL'($urandom);
                d[p] = $urandom;
                drive_port(p, mask[p], w[p], a[p], d[p]);
            end
            g   = next_grant(exp_last, mask);
            lat = $urandom_range(0, 6);
            tick;
            checks++; if ({c_req, 30'b0, grant_id} !== {1'b1, g}) begin
                errors++; $display("FAIL rnd_grant: it=%0d mask=%b got %0d exp %0d", it, mask, grant_id, g); end
            checks++; if ({c_read, c_addr, c_wdata} !== {~w[g], a[g], d[g]}) begin
                errors++; $display("FAIL rnd_bus: it=%0d got %b/%h/%h exp %b/%h/%h", it, c_read, c_addr, c_wdata, ~w[g], a[g], d[g]); end
            if ($urandom_range(0, 1) == 1) req_valid[g] = 1'b0;
            bad = 0;
            for (int c = 0; c < lat; c++) begin
                for (int p = 0; p < 3; p++) begin
                    req_addr[p*AL +: AL] = AL'($urandom);
                    req_wdata[p*DL +: DL] = $urandom;
                end
                req_we = 3'($urandom);
                tick;
                if ({c_req, c_read, c_addr, c_wdata, req_done} !== {1'b1, ~w[g], a[g], d[g], 3'b000}) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_hold: it=%0d got %0d bad cycles exp 0", it, bad); end
            rd = $urandom;
            c_done = 1'b1; c_rdata = rd;
            tick;
            checks++; if ({c_req, req_done, req_err, rsp_rdata} !== {1'b0, 3'(1 << g), 3'b000, rd}) begin
                errors++; $display("FAIL rnd_done: it=%0d got %b/%b/%h exp %b/000/%h", it, req_done, req_err, rsp_rdata, 3'(1 << g), rd); end
            c_done = 1'b0; req_valid = '0;
            exp_last = g;
            tick;
            checks++; if ({c_req, req_done} !== 4'b0) begin
                errors++; $display("FAIL rnd_idle: it=%0d got %b exp 0000", it, {c_req, req_done}); end
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_single_write;
        test_round_robin;
        test_timeout;
        test_collision;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
